uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Downstream consumer of the housekeeper synchronous FIFO.
- Pops DATA_WIDTH-bit words from the FIFO's show-ahead read port and serialises each word as DATA_WIDTH/8 UART frames, least-significant byte first.
- Each frame is 8N1: start bit, 8 data bits LSB-first, one stop bit.
- Bit period is set by a runtime clock divider; the block drives the housekeeper serial transmit pin.

Parameters:
- DATA_WIDTH, 32, FIFO word width; must be a multiple of 8, minimum 8.
- DIV_WIDTH, 16, width of the baud divider input and counter.

Ports:
- Clk  input  1  system clock
- ARst  input  1  asynchronous reset, active-high
- Enable  input  1  permits starting a new word; does not abort a word in progress
- ClkDiv  input  DIV_WIDTH  bit period minus one, in Clk cycles; 0 is illegal and is treated as 1
- FifoEmpty  input  1  FIFO Empty flag
- FifoRData  input  DATA_WIDTH  FIFO head word; valid whenever FifoEmpty=0
- FifoRen  output  1  single-cycle pop strobe to the FIFO
- Txd  output  1  serial output; idle high
- Busy  output  1  high from the pop cycle through the end of the last stop bit
- WordDone  output  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Reset (ARst=1, asynchronous):
  - State IDLE.
  - Txd=1, FifoRen=0, Busy=0, WordDone=0.
  - Shift register, byte counter, bit counter and baud counter all cleared.
  - Reset mid-frame: Txd returns high immediately, no further pops. The partially sent word is lost, but it was already removed from the FIFO.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If Enable=1 and FifoEmpty=0, assert FifoRen combinationally for exactly that cycle.
  - In the same cycle, capture FifoRData into the shift register, latch ClkDiv (effective max(ClkDiv,1)), set the byte counter to DATA_WIDTH/8-1, go to START.
  - FifoRen is never asserted when FifoEmpty=1, so the FIFO underflow flag never fires from this block.
  - FifoRen is never asserted outside IDLE.
- Bit timing:
  - Each bit lasts D+1 cycles, where D is the latched divider.
  - The baud counter loads D at bit start, decrements to 0, and the bit ends on the cycle the counter is 0.
  - ClkDiv changes take effect only at the next word.
- START: Txd=0 for one bit period, then DATA with bit counter 0.
- DATA:
  - Txd = shift register bit 0.
  - At each bit end, shift right by 1 and increment the bit counter.
  - After bit 7, go to STOP.
- STOP:
  - Txd=1 for one bit period.
  - At its end, if the byte counter is nonzero: decrement it and go to START. The shift register already holds the next byte in bits [7:0].
  - Otherwise pulse WordDone and go to IDLE.
- Throughput:
  - The next word's pop can occur on the cycle immediately after WordDone.
  - Gap between words is exactly 1 idle-high cycle (the IDLE pop cycle); the stop bit is not shortened.
  - Frame = 10*(D+1) cycles; word = BYTES*10*(D+1)+1 cycles, pop to pop.
- Enable:
  - Sampled only in IDLE.
  - Deasserting mid-word completes the whole word.
- Txd is registered (glitch-free), with no combinational path from inputs to Txd.
- FifoRen, Busy and WordDone are decoded from state/counters and Enable/FifoEmpty. Busy=1 in START/DATA/STOP and in the IDLE pop cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP
  - UART frame constants: 8 data bits, 10 bits per frame
- Natural sub-module: uart_baud_tick. It holds the divider latch and down-counter, with inputs Clk, ARst, Load, Div and output Tick. Tick is the bit-end strobe and is reused by a future RX block.

Test Plan:
- Reset idle: ARst pulse, FifoEmpty=1 for 100 cycles -> Txd=1, FifoRen=0, Busy=0 throughout.
- Single word: ClkDiv=3, FIFO holds 0xA55A0F01, Enable=1.
  - Exactly one FifoRen pulse.
  - Txd carries bytes 0x01, 0x0F, 0x5A, 0xA5, each 8N1 at 4 cycles/bit.
  - WordDone 160 cycles after the pop cycle.
- Back-to-back: push 0x11223344 and 0x55667788, ClkDiv=1 -> second FifoRen exactly 1 cycle after first WordDone, pop-to-pop 81 cycles, decoded byte stream 44 33 22 11 88 77 66 55.
- Enable drop mid-word: deassert Enable during byte 1 of 0xDEADBEEF with a second word queued -> all 4 bytes sent, no second pop until Enable is reasserted.
- Divider edge cases: ClkDiv=0 gives 2 cycles/bit. ClkDiv changed from 3 to 7 mid-word -> current word stays at 4 cycles/bit, next word at 8 cycles/bit.
- Reset mid-frame: assert ARst during a DATA bit -> Txd=1 the same cycle (asynchronous), Busy=0, no FifoRen until ARst is released and FifoEmpty=0; the next word transmits correctly.

Source files
------------

// File: rtl/uart_word_tx_pkg.sv
// Shared constants for the word-serialising UART transmitter.
// FSM state encoding and 8N1 frame geometry.
package uart_word_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_BITS      = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period generator: latches the divider on Load and strobes Tick on
// the last cycle of every bit period (D+1 cycles, D = max(Div,1)).
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 ARst,
  input  logic                 Load,
  input  logic [DIV_WIDTH-1:0] Div,
  output logic                 Tick
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_eff;

  assign div_eff = (Div == '0) ? DIV_WIDTH'(1) : Div;
  assign Tick    = (cnt_q == '0);

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (Load) begin
      div_q <= div_eff;
      cnt_q <= div_eff;
    end else if (Tick) begin
      cnt_q <= div_q;
    end else begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Pops words from a show-ahead FIFO and sends each as DATA_WIDTH/8 8N1
// frames, least-significant byte first, on a registered Txd.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting; pops a word when Enable and not empty
// ST_START | start bit (Txd=0) for one bit period
// ST_DATA  | 8 data bits, LSB first, from shift_q[0]
// ST_STOP  | stop bit (Txd=1); next byte or word done
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  ARst,
  input  logic                  Enable,
  input  logic [DIV_WIDTH-1:0]  ClkDiv,
  input  logic                  FifoEmpty,
  input  logic [DATA_WIDTH-1:0] FifoRData,
  output logic                  FifoRen,
  output logic                  Txd,
  output logic                  Busy,
  output logic                  WordDone
);

  localparam int BYTES = DATA_WIDTH / FRAME_DATA_BITS;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
  // frame minus start and stop bits, counted from zero
  localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BC_W-1:0]       byte_cnt_q;
  logic [2:0]            bit_cnt_q;
  logic                  txd_q;
  logic                  tick;
  logic                  pop;

  // Gated by ARst so nothing is popped while held in reset.
  assign pop      = !ARst && (state_q == ST_IDLE) && Enable && !FifoEmpty;
  assign FifoRen  = pop;
  assign Busy     = (state_q != ST_IDLE) || pop;
  assign WordDone = (state_q == ST_STOP) && tick && (byte_cnt_q == '0);
  assign Txd      = txd_q;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .Clk  (Clk),
    .ARst (ARst),
    .Load (pop),
    .Div  (ClkDiv),
    .Tick (tick)
  );

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q    <= FifoRData;
            byte_cnt_q <= LAST_BYTE;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd_q     <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_DATA_BIT) begin
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (byte_cnt_q != '0) begin
              byte_cnt_q <= byte_cnt_q - BC_W'(1);
              txd_q      <= 1'b0;
              state_q    <= ST_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: models a show-ahead FIFO and checks
// every bit period of the serial stream cycle-by-cycle.
module tb_uart_word_tx;

  logic        Clk;
  logic        ARst;
  logic        Enable;
  logic [15:0] ClkDiv;
  logic        FifoEmpty;
  logic [31:0] FifoRData;
  logic        FifoRen;
  logic        Txd;
  logic        Busy;
  logic        WordDone;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int pop_count = 0;
  int last_pop_cyc = 0;
  int ren_empty_err = 0;

  assign FifoEmpty = (rd_ptr == wr_ptr);
  assign FifoRData = mem[rd_ptr[5:0]];

  uart_word_tx dut (
    .Clk       (Clk),
    .ARst      (ARst),
    .Enable    (Enable),
    .ClkDiv    (ClkDiv),
    .FifoEmpty (FifoEmpty),
    .FifoRData (FifoRData),
    .FifoRen   (FifoRen),
    .Txd       (Txd),
    .Busy      (Busy),
    .WordDone  (WordDone)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (FifoRen === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge Clk) begin
    if (FifoRen === 1'b1) begin
      pop_count    <= pop_count + 1;
      last_pop_cyc <= cyc;
      if (FifoEmpty) ren_empty_err <= ren_empty_err + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pop(input string name, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 400; i++) begin
      if (FifoRen === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s pop_timeout: FifoRen=%b after 400 cycles, required 1", name, FifoRen);
    end
  endtask

  // Called on the pop-cycle negedge; walks every cycle of the word.
  task automatic expect_word(input logic [31:0] w, input int p, input int drop_byte,
                             input int div_byte, input logic [15:0] div_new, input string name);
    logic [7:0] bv;
    logic       exp;
    int bad, wd_count, wd_pos, pos;
    wd_count = 0;
    wd_pos   = -1;
    pos      = 0;
    for (int b = 0; b < 4; b++) begin
      bv = w[8*b +: 8];
      for (int k = 0; k < 10; k++) begin
        if (k == 0 && b == drop_byte) Enable = 1'b0;
        if (k == 0 && b == div_byte) ClkDiv = div_new;
        exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bv[k-1];
        bad = 0;
        for (int c = 0; c < p; c++) begin
          @(negedge Clk);
          pos++;
          if (Txd !== exp || Busy !== 1'b1) bad++;
          if (WordDone === 1'b1) begin
            wd_count++;
            wd_pos = pos;
          end
        end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL %s byte%0d bit%0d: %0d bad cycles (Txd=%b Busy=%b), required Txd=%b Busy=1 for %0d cycles",
                   name, b, k, bad, Txd, Busy, exp, p);
        end
      end
    end
    checks++;
    if (wd_count != 1 || wd_pos != 40*p) begin
      failures++;
      $display("FAIL %s word_done: %0d pulses, last at +%0d, required 1 pulse at +%0d",
               name, wd_count, wd_pos, 40*p);
    end
  endtask

  task automatic test_reset();
    int bad;
    ARst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (Txd !== 1'b1 || FifoRen !== 1'b0 || Busy !== 1'b0 || WordDone !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: Txd=%b FifoRen=%b Busy=%b WordDone=%b, required 1 0 0 0",
               Txd, FifoRen, Busy, WordDone);
    end
    ARst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge Clk);
      if (Txd !== 1'b1 || FifoRen !== 1'b0 || Busy !== 1'b0 || WordDone !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_single_word();
    bit ok;
    int pc;
    ClkDiv = 16'd3;
    push(32'hA55A0F01);
    Enable = 1'b1;
    pc = pop_count;
    wait_pop("single", ok);
    if (ok) expect_word(32'hA55A0F01, 4, -1, -1, 16'd0, "single");
    repeat (20) @(negedge Clk);
    checks++;
    if (pop_count - pc != 1) begin
      failures++;
      $display("FAIL single_pops: %0d pops, required 1", pop_count - pc);
    end
    Enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p1;
    ClkDiv = 16'd1;
    push(32'h11223344);
    push(32'h55667788);
    Enable = 1'b1;
    wait_pop("b2b_first", ok);
    p1 = cyc;
    if (ok) begin
      expect_word(32'h11223344, 2, -1, -1, 16'd0, "b2b_w1");
      @(negedge Clk);
      checks++;
      if (FifoRen !== 1'b1 || Txd !== 1'b1) begin
        failures++;
        $display("FAIL b2b_second_pop: FifoRen=%b Txd=%b after WordDone, required 1 1", FifoRen, Txd);
      end
      expect_word(32'h55667788, 2, -1, -1, 16'd0, "b2b_w2");
      checks++;
      if (last_pop_cyc - p1 != 81) begin
        failures++;
        $display("FAIL b2b_pop_to_pop: %0d cycles, required 81", last_pop_cyc - p1);
      end
    end
    Enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int pc;
    ClkDiv = 16'd3;
    push(32'hDEADBEEF);
    push(32'h0BADF00D);
    Enable = 1'b1;
    wait_pop("endrop_first", ok);
    if (ok) expect_word(32'hDEADBEEF, 4, 1, -1, 16'd0, "endrop_w1");
    pc = pop_count;
    repeat (40) @(negedge Clk);
    checks++;
    if (pop_count != pc || FifoEmpty !== 1'b0) begin
      failures++;
      $display("FAIL endrop_no_pop: %0d pops while disabled (empty=%b), required 0 pops, empty=0",
               pop_count - pc, FifoEmpty);
    end
    Enable = 1'b1;
    wait_pop("endrop_second", ok);
    if (ok) expect_word(32'h0BADF00D, 4, -1, -1, 16'd0, "endrop_w2");
    Enable = 1'b0;
  endtask

  task automatic test_divider();
    bit ok;
    ClkDiv = 16'd0;
    push(32'h3C00C3FF);
    Enable = 1'b1;
    wait_pop("div0", ok);
    if (ok) expect_word(32'h3C00C3FF, 2, -1, -1, 16'd0, "div0");
    Enable = 1'b0;
    repeat (3) @(negedge Clk);
    ClkDiv = 16'd3;
    push(32'h81422418);
    push(32'hF00F55AA);
    Enable = 1'b1;
    wait_pop("divchg_first", ok);
    if (ok) begin
      expect_word(32'h81422418, 4, -1, 1, 16'd7, "divchg_w1");
      wait_pop("divchg_second", ok);
      if (ok) expect_word(32'hF00F55AA, 8, -1, -1, 16'd0, "divchg_w2");
    end
    Enable = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int bad;
    ClkDiv = 16'd3;
    push(32'h12345600);
    push(32'h5A5AA5A5);
    Enable = 1'b1;
    wait_pop("rstmid_first", ok);
    if (ok) begin
      repeat (5) @(negedge Clk);
      checks++;
      if (Txd !== 1'b0 || Busy !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_pre: Txd=%b Busy=%b in data bit 0, required 0 1", Txd, Busy);
      end
      ARst = 1'b1;
      #1;
      checks++;
      if (Txd !== 1'b1 || Busy !== 1'b0 || FifoRen !== 1'b0 || WordDone !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_async: Txd=%b Busy=%b FifoRen=%b WordDone=%b, required 1 0 0 0",
                 Txd, Busy, FifoRen, WordDone);
      end
      bad = 0;
      repeat (4) begin
        @(negedge Clk);
        if (FifoRen !== 1'b0 || Txd !== 1'b1 || Busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rstmid_hold: %0d active cycles in reset, required 0", bad);
      end
      ARst = 1'b0;
      wait_pop("rstmid_second", ok);
      if (ok) expect_word(32'h5A5AA5A5, 4, -1, -1, 16'd0, "rstmid_w2");
    end
    Enable = 1'b0;
  endtask

  task automatic test_final();
    repeat (5) @(negedge Clk);
    checks++;
    if (ren_empty_err != 0) begin
      failures++;
      $display("FAIL ren_when_empty: %0d pops on empty FIFO, required 0", ren_empty_err);
    end
    checks++;
    if (rd_ptr != wr_ptr) begin
      failures++;
      $display("FAIL fifo_drained: %0d words left, required 0", wr_ptr - rd_ptr);
    end
  endtask

  initial begin
    ARst   = 1'b1;
    Enable = 1'b0;
    ClkDiv = 16'd3;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_divider();
    test_reset_mid_frame();
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
